// File: rtl/fact_pkg.sv
// Shared definitions for the round-robin factorial scheduler: FSM encoding
// and the widths of the factorial core interface.
package fact_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int FACT_NMAX = 12;
    localparam int PRODW     = 32;
    localparam int NW        = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr,
// searching upward with wrap-around.
module rr_arbiter
    import fact_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id,
    output logic            any
);

    int idx;

    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                id         = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/fact_rr_scheduler.sv
// Shares one factorial core between NREQ requesters: round-robin grant,
// single job in flight, done/error/timeout supervision, tagged response.
module fact_rr_scheduler
    import fact_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ),
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [4*NREQ-1:0] req_n,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [PRODW-1:0]  rsp_product,
    output logic              rsp_error,
    output logic              rsp_timeout,
    output logic              fct_go,
    output logic [NW-1:0]     fct_n,
    input  logic              fct_done,
    input  logic              fct_error,
    input  logic [PRODW-1:0]  fct_product,
    output logic              busy
);

    localparam int CNTW = $clog2(TIMEOUT);

    state_t            state, state_next;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    job_id;
    logic [NW-1:0]     job_n;
    logic [CNTW-1:0]   cnt;
    logic [PRODW-1:0]  prod_q;
    logic              err_q;
    logic              to_q;

    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_id;
    logic              grant_any;
    logic [NW-1:0]     sel_n;
    logic              timeout_hit;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .id    (grant_id),
        .any   (grant_any)
    );

    assign sel_n = req_n[NW*int'(grant_id) +: NW];

    // Fires on the cycle whose increment brings the counter to TIMEOUT-1,
    // so rsp_valid rises exactly TIMEOUT cycles after fct_go.
    assign timeout_hit = (cnt == CNTW'(TIMEOUT - 2));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            rr_ptr <= '0;
            job_id <= '0;
            job_n  <= '0;
            cnt    <= '0;
            prod_q <= '0;
            err_q  <= 1'b0;
            to_q   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        job_id <= grant_id;
                        job_n  <= sel_n;
                    end
                end
                S_ISSUE: begin
                    cnt <= '0;
                end
                S_WAIT: begin
                    cnt <= cnt + CNTW'(1);
                    if (fct_error) begin
                        prod_q <= '0;
                        err_q  <= 1'b1;
                        to_q   <= 1'b0;
                    end else if (fct_done) begin
                        prod_q <= fct_product;
                        err_q  <= 1'b0;
                        to_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        prod_q <= '0;
                        err_q  <= 1'b1;
                        to_q   <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rr_ptr <= (job_id == IDW'(NREQ - 1)) ? '0 : job_id + IDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Grants only leave IDLE; the handshake cycle in RESP never grants.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        fct_go     = 1'b0;
        case (state)
            S_IDLE: begin
                if (rst) begin
                    req_ready = grant;
                end
                if (grant_any) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fct_go     = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (fct_error || fct_done || timeout_hit) begin
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign fct_n       = job_n;
    assign rsp_valid   = (state == S_RESP);
    assign rsp_id      = job_id;
    assign rsp_product = prod_q;
    assign rsp_error   = err_q;
    assign rsp_timeout = to_q;
    assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_fact_rr_scheduler.sv
// Directed, table-driven bench for fact_rr_scheduler; the factorial core is
// played by the bench with hand-computed products.
module tb_fact_rr_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TMO  = 64;

    localparam int MODE_DONE   = 0;
    localparam int MODE_ERR    = 1;
    localparam int MODE_SILENT = 2;
    localparam int MODE_BOTH   = 3;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_n;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_product;
    logic              rsp_error;
    logic              rsp_timeout;
    logic              fct_go;
    logic [3:0]        fct_n;
    logic              fct_done;
    logic              fct_error;
    logic [31:0]       fct_product;
    logic              busy;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       name;
        logic [3:0]  req_valid;
        logic [15:0] req_n;
        int          mode;
        int          lat;
        logic [31:0] core_product;
        logic [3:0]  exp_grant;
        logic [3:0]  exp_n;
        logic [1:0]  exp_id;
        logic [31:0] exp_product;
        logic        exp_error;
        logic        exp_timeout;
    } vec_t;

    vec_t vecs[11];

    fact_rr_scheduler #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_n       (req_n),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .fct_go      (fct_go),
        .fct_n       (fct_n),
        .fct_done    (fct_done),
        .fct_error   (fct_error),
        .fct_product (fct_product),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // One complete job from IDLE through the response handshake.
    task automatic applyStimulus(input vec_t v);
        int cyc;
        int exp_cyc;
        req_valid = v.req_valid;
        req_n     = v.req_n;
        #1;
        checkOutput({v.name, " grant"}, 32'(req_ready), 32'(v.exp_grant));
        tick();
        req_valid = '0;
        checkOutput({v.name, " go"}, 32'(fct_go), 32'd1);
        checkOutput({v.name, " fct_n"}, 32'(fct_n), 32'(v.exp_n));
        cyc = 0;
        if (v.mode != MODE_SILENT) begin
            tick();
            cyc = 1;
            checkOutput({v.name, " go pulse"}, 32'(fct_go), 32'd0);
            while (cyc < v.lat) begin
                tick();
                cyc++;
            end
            fct_done    = (v.mode == MODE_DONE) || (v.mode == MODE_BOTH);
            fct_error   = (v.mode == MODE_ERR) || (v.mode == MODE_BOTH);
            fct_product = v.core_product;
            tick();
            cyc++;
            fct_done    = 1'b0;
            fct_error   = 1'b0;
            fct_product = 32'hFFFF_FFFF;
            exp_cyc     = v.lat + 1;
        end else begin
            exp_cyc = TMO;
        end
        while (!rsp_valid && cyc < 300) begin
            tick();
            cyc++;
        end
        checkOutput({v.name, " rsp latency"}, 32'(cyc), 32'(exp_cyc));
        checkOutput({v.name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({v.name, " rsp_id"}, 32'(rsp_id), 32'(v.exp_id));
        checkOutput({v.name, " rsp_product"}, rsp_product, v.exp_product);
        checkOutput({v.name, " rsp_error"}, 32'(rsp_error), 32'(v.exp_error));
        checkOutput({v.name, " rsp_timeout"}, 32'(rsp_timeout), 32'(v.exp_timeout));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkOutput({v.name, " release"}, 32'({rsp_valid, busy}), 32'd0);
    endtask

    initial begin
        int seen;

        vecs[0]  = '{"rr0", 4'hF, 16'h4321, MODE_DONE, 2, 32'd1, 4'b0001, 4'd1, 2'd0, 32'd1, 1'b0, 1'b0};
        vecs[1]  = '{"rr1", 4'hF, 16'h4321, MODE_DONE, 1, 32'd2, 4'b0010, 4'd2, 2'd1, 32'd2, 1'b0, 1'b0};
        vecs[2]  = '{"rr2", 4'hF, 16'h4321, MODE_DONE, 3, 32'd6, 4'b0100, 4'd3, 2'd2, 32'd6, 1'b0, 1'b0};
        vecs[3]  = '{"rr3", 4'hF, 16'h4321, MODE_DONE, 1, 32'd24, 4'b1000, 4'd4, 2'd3, 32'd24, 1'b0, 1'b0};
        vecs[4]  = '{"rr4", 4'hF, 16'h4321, MODE_DONE, 2, 32'd1, 4'b0001, 4'd1, 2'd0, 32'd1, 1'b0, 1'b0};
        vecs[5]  = '{"single", 4'b0001, 16'h0005, MODE_DONE, 4, 32'd120, 4'b0001, 4'd5, 2'd0, 32'd120, 1'b0, 1'b0};
        vecs[6]  = '{"err13", 4'b0100, 16'h0D00, MODE_ERR, 2, 32'hDEADBEEF, 4'b0100, 4'd13, 2'd2, 32'd0, 1'b1, 1'b0};
        vecs[7]  = '{"after_err", 4'b1010, 16'h7060, MODE_DONE, 3, 32'd5040, 4'b1000, 4'd7, 2'd3, 32'd5040, 1'b0, 1'b0};
        vecs[8]  = '{"n12", 4'b0110, 16'h03C0, MODE_DONE, 5, 32'd479001600, 4'b0010, 4'd12, 2'd1, 32'd479001600, 1'b0, 1'b0};
        vecs[9]  = '{"done_and_err", 4'b0100, 16'h0300, MODE_BOTH, 1, 32'd6, 4'b0100, 4'd3, 2'd2, 32'd0, 1'b1, 1'b0};
        vecs[10] = '{"timeout", 4'b1000, 16'h9000, MODE_SILENT, 0, 32'd0, 4'b1000, 4'd9, 2'd3, 32'd0, 1'b1, 1'b1};

        rst         = 1'b0;
        req_valid   = '0;
        req_n       = '0;
        rsp_ready   = 1'b0;
        fct_done    = 1'b0;
        fct_error   = 1'b0;
        fct_product = '0;
        tick();
        tick();
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset fct_go", 32'(fct_go), 32'd0);
        checkOutput("reset fct_n", 32'(fct_n), 32'd0);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_fields", {rsp_product[28:0], rsp_id, rsp_error}, 32'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

        // Backpressure: response held for 10 cycles while everyone requests.
        req_valid = 4'b0001;
        req_n     = 16'h0004;
        #1;
        checkOutput("bp grant", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        checkOutput("bp go", 32'(fct_go), 32'd1);
        tick();
        fct_done    = 1'b1;
        fct_product = 32'd24;
        tick();
        fct_done    = 1'b0;
        fct_product = 32'hFFFF_FFFF;
        req_valid   = 4'hF;
        req_n       = 16'h4321;
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput("bp rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp rsp_product", rsp_product, 32'd24);
            checkOutput("bp rsp_id", 32'(rsp_id), 32'd0);
            checkOutput("bp req_ready", 32'(req_ready), 32'd0);
            checkOutput("bp fct_go", 32'(fct_go), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checkOutput("handshake no grant", 32'(req_ready), 32'd0);
        tick();
        rsp_ready = 1'b0;
        #1;
        checkOutput("bp next grant", 32'(req_ready), 32'b0010);
        req_valid = '0;
        #1;
        tick();
        checkOutput("bp idle", 32'(busy), 32'd0);

        // Reset while the core is working: job dropped, pointer back to 0.
        req_valid = 4'b0100;
        req_n     = 16'h0500;
        #1;
        checkOutput("rst grant", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        tick();
        checkOutput("rst in wait", 32'(busy), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        checkOutput("rst busy", 32'(busy), 32'd0);
        checkOutput("rst fct_go", 32'(fct_go), 32'd0);
        checkOutput("rst fct_n", 32'(fct_n), 32'd0);
        checkOutput("rst rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("rst rsp_product", rsp_product, 32'd0);
        checkOutput("rst rsp_flags", 32'({rsp_error, rsp_timeout}), 32'd0);
        fct_done    = 1'b1;
        fct_product = 32'd120;
        tick();
        fct_done = 1'b0;
        seen     = 0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid) seen++;
            tick();
        end
        checkOutput("rst dropped job", 32'(seen), 32'd0);
        req_valid = 4'hF;
        #1;
        checkOutput("rst rr_ptr", 32'(req_ready), 32'b0001);
        req_valid = '0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
